regs_job_sequencer: RTL and testbench
=====================================

Name: regs_job_sequencer

Overview:
- Local-bus master that runs one job on the CSR block per request.
- Sequence: write DATA, write CTRL, pulse START, then poll STATUS until a done bit is set or the poll budget runs out.
- Sits between the job-issuing logic and the CSR block's local-bus slave port, and is the only master on that port.
- Returns the final STATUS byte and a timeout flag through a valid/ready result interface.

Parameters:
- ADDR_W, 16, local-bus address width.
- DATA_W, 32, local-bus data width.
- DATA_ADDR, 16'h0, DATA register address.
- CTRL_ADDR, 16'h4, CTRL register address.
- STATUS_ADDR, 16'h8, STATUS register address.
- START_ADDR, 16'h100, START register address.
- DONE_MASK, 8'h01, STATUS bits meaning "job complete".
- MAX_POLLS, 1024, STATUS reads before timeout (>=1).
- POLL_GAP, 4, idle cycles between consecutive STATUS reads (>=0).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- job_valid  in  1  job request.
- job_ready  out  1  job accepted when both job_valid and job_ready are high.
- job_data  in  32  value for DATA.
- job_ctrl  in  16  value for CTRL.val.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when both res_valid and res_ready are high.
- res_status  out  8  last STATUS[7:0] read.
- res_timeout  out  1  poll budget exhausted.
- busy  out  1  high in every state except IDLE.
- lb_waddr  out  16  write address.
- lb_wdata  out  32  write data.
- lb_wstrb  out  4  byte strobes.
- lb_wen  out  1  write request.
- lb_wready  in  1  write accepted.
- lb_raddr  out  16  read address.
- lb_ren  out  1  read request pulse.
- lb_rdata  in  32  read data.
- lb_rvalid  in  1  read data valid.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state IDLE.
  - job_ready=1; res_valid=0; res_status=0; res_timeout=0; busy=0.
  - lb_wen=0; lb_ren=0; lb_waddr/lb_wdata/lb_wstrb/lb_raddr=0.
  - Poll and gap counters 0.
- Reset mid-job: aborts immediately; no further bus cycles are issued. An outstanding read's lb_rvalid is ignored.
- All outputs are registered. job_ready = (state==IDLE).
- States: IDLE, WR_DATA, WR_CTRL, WR_START, RD_REQ, RD_WAIT, GAP, RESULT.
- IDLE: on job_valid&&job_ready, latch job_data and job_ctrl, clear the poll counter, go to WR_DATA. lb_wen rises the cycle after acceptance.
- Write handshake:
  - lb_wen, lb_waddr, lb_wdata and lb_wstrb are held stable until a cycle where lb_wen&&lb_wready.
  - The next state's write is presented on the following cycle, so lb_wen may stay high across back-to-back writes with new address/data.
  - lb_wready=1 continuously gives 1 cycle per write.
- Write values:
  - WR_DATA: DATA_ADDR, job_data, strobe 4'hF.
  - WR_CTRL: CTRL_ADDR, {16'h0, job_ctrl}, strobe 4'h3.
  - WR_START: START_ADDR, 32'h1, strobe 4'h1.
  - After the START write is accepted, lb_wen=0 and the state goes to RD_REQ.
- RD_REQ: lb_ren=1 for exactly one cycle with lb_raddr=STATUS_ADDR; poll counter +1; go to RD_WAIT.
- RD_WAIT: lb_ren=0; wait for lb_rvalid with no bound. On lb_rvalid, capture res_status=lb_rdata[7:0], then:
  - (lb_rdata[7:0] & DONE_MASK) != 0: go to RESULT with res_timeout=0.
  - Otherwise, if poll counter == MAX_POLLS: go to RESULT with res_timeout=1.
  - Otherwise: go to GAP. If POLL_GAP==0, go straight to RD_REQ instead.
- Done takes priority over timeout on the final poll.
- GAP: count POLL_GAP cycles, then RD_REQ. Read-to-read spacing is POLL_GAP+2 cycles when lb_rvalid arrives the cycle after lb_ren.
- RESULT:
  - res_valid=1 with res_status and res_timeout stable until res_valid&&res_ready.
  - Then res_valid=0, state IDLE, job_ready=1 the next cycle.
  - A new job cannot be accepted in the same cycle as result consumption.
- lb_wen and lb_ren are never high in the same cycle.
- Poll counter width is clog2(MAX_POLLS+1) and it saturates; it never wraps.
- Minimum latency with wready=1, rvalid one cycle after ren, and done on the first poll: acceptance to res_valid = 6 cycles.

Test Plan:
- Basic job: job_data=32'hDEADBEEF, job_ctrl=16'h0100; wready tied 1; STATUS returns 8'h01 on the first read -> writes (0x0,DEADBEEF,F), (0x4,00000100,3), (0x100,1,1) in consecutive cycles; 1 read of 0x8; res_status=8'h01, res_timeout=0; res_valid 6 cycles after acceptance.
- Write backpressure: lb_wready low for 3 cycles on each write -> address/data/strobe held stable, no write duplicated or skipped, same write order.
- Multi-poll: STATUS returns 0x00, 0x00, 0x81; POLL_GAP=4 -> exactly 3 reads at 6-cycle spacing; res_status=8'h81, res_timeout=0.
- Timeout: MAX_POLLS=3, STATUS always 0x02 -> exactly 3 reads; res_timeout=1, res_status=8'h02. Variant where the 3rd read returns 0x01 -> res_timeout=0.
- Result backpressure and back-to-back jobs: res_ready low for 5 cycles -> res_valid and outputs held, job_ready=0, a pending job_valid is not accepted; after the handshake, the second job is accepted on the next cycle.
- Reset mid-poll: assert rst in RD_WAIT and then drive a late lb_rvalid -> all outputs at reset values, state IDLE, no res_valid; a fresh job afterwards completes normally.

Source files
------------

// File: rtl/regs_job_sequencer.sv
// Local-bus master that runs one CSR job per request: DATA, CTRL, START writes,
// then STATUS polling until done or the poll budget is spent.
module regs_job_sequencer #(
   parameter int                ADDR_W      = 16,
   parameter int                DATA_W      = 32,
   parameter logic [ADDR_W-1:0] DATA_ADDR   = 16'h0,
   parameter logic [ADDR_W-1:0] CTRL_ADDR   = 16'h4,
   parameter logic [ADDR_W-1:0] STATUS_ADDR = 16'h8,
   parameter logic [ADDR_W-1:0] START_ADDR  = 16'h100,
   parameter logic [7:0]        DONE_MASK   = 8'h01,
   parameter int                MAX_POLLS   = 1024,
   parameter int                POLL_GAP    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                job_valid,
   output logic                job_ready,
   input  logic [DATA_W-1:0]   job_data,
   input  logic [15:0]         job_ctrl,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [7:0]          res_status,
   output logic                res_timeout,
   output logic                busy,
   output logic [ADDR_W-1:0]   lb_waddr,
   output logic [DATA_W-1:0]   lb_wdata,
   output logic [DATA_W/8-1:0] lb_wstrb,
   output logic                lb_wen,
   input  logic                lb_wready,
   output logic [ADDR_W-1:0]   lb_raddr,
   output logic                lb_ren,
   input  logic [DATA_W-1:0]   lb_rdata,
   input  logic                lb_rvalid
);

   localparam int STRB_W = DATA_W / 8;
   localparam int PW     = $clog2(MAX_POLLS + 1);
   localparam int GW     = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
   localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLLS);
   localparam logic [GW-1:0] GAP_LAST  = (POLL_GAP > 0) ? GW'(POLL_GAP - 1) : '0;

   typedef enum logic [2:0] {
      IDLE, WR_DATA, WR_CTRL, WR_START, RD_REQ, RD_WAIT, GAP, RESULT
   } state_t;

   state_t state, state_d;

   logic [PW-1:0]     poll_cnt;
   logic [GW-1:0]     gap_cnt;
   logic [DATA_W-1:0] data_q;
   logic [15:0]       ctrl_q;

   logic                job_ready_d, busy_d, res_valid_d, lb_ren_d, lb_wen_d;
   logic [ADDR_W-1:0]   lb_raddr_d, lb_waddr_d;
   logic [DATA_W-1:0]   lb_wdata_d;
   logic [STRB_W-1:0]   lb_wstrb_d;

   logic accept, wr_done, rd_done, is_done, unused_rdata;

   assign accept       = job_valid && job_ready;
   assign wr_done      = lb_wen && lb_wready;
   assign rd_done      = (state == RD_WAIT) && lb_rvalid;
   assign is_done      = |(lb_rdata[7:0] & DONE_MASK);
   assign unused_rdata = ^lb_rdata[DATA_W-1:8];

   // State, counters, job latches and the registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         poll_cnt    <= '0;
         gap_cnt     <= '0;
         data_q      <= '0;
         ctrl_q      <= '0;
         job_ready   <= 1'b1;
         busy        <= 1'b0;
         res_valid   <= 1'b0;
         res_status  <= '0;
         res_timeout <= 1'b0;
         lb_wen      <= 1'b0;
         lb_waddr    <= '0;
         lb_wdata    <= '0;
         lb_wstrb    <= '0;
         lb_ren      <= 1'b0;
         lb_raddr    <= '0;
      end else begin
         state <= state_d;
         if (accept) begin
            data_q   <= job_data;
            ctrl_q   <= job_ctrl;
            poll_cnt <= '0;
         end else if (state == RD_REQ && poll_cnt != POLL_LAST) begin
            poll_cnt <= poll_cnt + 1'b1;
         end
         gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
         if (rd_done) begin
            res_status  <= lb_rdata[7:0];
            res_timeout <= !is_done && (poll_cnt == POLL_LAST);
         end
         job_ready <= job_ready_d;
         busy      <= busy_d;
         res_valid <= res_valid_d;
         lb_wen    <= lb_wen_d;
         lb_waddr  <= lb_waddr_d;
         lb_wdata  <= lb_wdata_d;
         lb_wstrb  <= lb_wstrb_d;
         lb_ren    <= lb_ren_d;
         lb_raddr  <= lb_raddr_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:     if (accept) state_d = WR_DATA;
         WR_DATA:  if (wr_done) state_d = WR_CTRL;
         WR_CTRL:  if (wr_done) state_d = WR_START;
         WR_START: if (wr_done) state_d = RD_REQ;
         RD_REQ:   state_d = RD_WAIT;
         RD_WAIT: begin
            if (lb_rvalid) begin
               if (is_done || poll_cnt == POLL_LAST) state_d = RESULT;
               else if (POLL_GAP == 0)               state_d = RD_REQ;
               else                                  state_d = GAP;
            end
         end
         GAP:      if (gap_cnt == GAP_LAST) state_d = RD_REQ;
         RESULT:   if (res_valid && res_ready) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register in step with it;
   // DATA is taken straight from job_data on the accepting cycle.
   always_comb begin
      job_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
      res_valid_d = (state_d == RESULT);
      lb_ren_d    = (state_d == RD_REQ);
      lb_raddr_d  = (state_d == RD_REQ) ? STATUS_ADDR : '0;
      lb_wen_d    = 1'b0;
      lb_waddr_d  = '0;
      lb_wdata_d  = '0;
      lb_wstrb_d  = '0;
      case (state_d)
         WR_DATA: begin
            lb_wen_d   = 1'b1;
            lb_waddr_d = DATA_ADDR;
            lb_wdata_d = (state == IDLE) ? job_data : data_q;
            lb_wstrb_d = '1;
         end
         WR_CTRL: begin
            lb_wen_d   = 1'b1;
            lb_waddr_d = CTRL_ADDR;
            lb_wdata_d = DATA_W'(ctrl_q);
            lb_wstrb_d = STRB_W'(4'h3);
         end
         WR_START: begin
            lb_wen_d   = 1'b1;
            lb_waddr_d = START_ADDR;
            lb_wdata_d = DATA_W'(1);
            lb_wstrb_d = STRB_W'(4'h1);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_regs_job_sequencer.sv
// Directed bench for regs_job_sequencer with a behavioural CSR slave that
// supports write stalls and delayed read data.
module tb_regs_job_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        job_valid, job_ready;
   logic [31:0] job_data;
   logic [15:0] job_ctrl;
   logic        res_valid, res_ready;
   logic [7:0]  res_status;
   logic        res_timeout, busy;
   logic [15:0] lb_waddr, lb_raddr;
   logic [31:0] lb_wdata;
   logic [3:0]  lb_wstrb;
   logic        lb_wen, lb_ren;
   logic        lb_wready = 1'b1;
   logic [31:0] lb_rdata  = '0;
   logic        lb_rvalid = 1'b0;

   always #5 clk = ~clk;

   regs_job_sequencer #(.MAX_POLLS(3), .POLL_GAP(4)) dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_data(job_data), .job_ctrl(job_ctrl),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_status(res_status), .res_timeout(res_timeout), .busy(busy),
      .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wstrb(lb_wstrb),
      .lb_wen(lb_wen), .lb_wready(lb_wready),
      .lb_raddr(lb_raddr), .lb_ren(lb_ren),
      .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Slave: STATUS values come from st_arr in read order.
   logic       stall_en = 1'b0;
   int         rd_delay = 0;
   logic [7:0] st_arr[256];
   int         rd_idx   = 0;
   logic       rd_pend  = 1'b0;
   int         rd_cnt   = 0;
   int         wait_cnt = 0;

   always @(negedge clk) begin
      lb_rvalid = 1'b0;
      lb_rdata  = '0;
      if (rd_pend) begin
         if (rd_cnt == 0) begin
            lb_rvalid = 1'b1;
            lb_rdata  = {24'hA5A5A4, st_arr[rd_idx & 255]};
            rd_idx++;
            rd_pend = 1'b0;
         end else begin
            rd_cnt--;
         end
      end
      if (lb_ren === 1'b1) begin
         rd_pend = 1'b1;
         rd_cnt  = rd_delay;
      end
      if (lb_wen === 1'b1) begin
         if (stall_en && wait_cnt < 3) begin
            lb_wready = 1'b0;
            wait_cnt++;
         end else begin
            lb_wready = 1'b1;
            wait_cnt  = 0;
         end
      end else begin
         lb_wready = !stall_en;
         wait_cnt  = 0;
      end
   end

   // Bus monitor: logs accepted writes, reads, acceptances and hold violations.
   int          cyc = 0, wn = 0, rn = 0, acc_n = 0, hold_err = 0, conflict_n = 0;
   logic [15:0] w_addr[64];
   logic [31:0] w_data[64];
   logic [3:0]  w_strb[64];
   int          w_cyc[64];
   logic [15:0] r_addr[64];
   int          r_cyc[64];
   logic        hold_pend = 1'b0;
   logic [15:0] s_addr;
   logic [31:0] s_data;
   logic [3:0]  s_strb;

   always @(posedge clk) begin
      if (hold_pend && (lb_wen !== 1'b1 || lb_waddr !== s_addr ||
                        lb_wdata !== s_data || lb_wstrb !== s_strb))
         hold_err++;
      hold_pend = (lb_wen === 1'b1) && (lb_wready === 1'b0);
      s_addr = lb_waddr;
      s_data = lb_wdata;
      s_strb = lb_wstrb;
      if (lb_wen === 1'b1 && lb_wready === 1'b1) begin
         w_addr[wn & 63] = lb_waddr;
         w_data[wn & 63] = lb_wdata;
         w_strb[wn & 63] = lb_wstrb;
         w_cyc[wn & 63]  = cyc;
         wn++;
      end
      if (lb_ren === 1'b1) begin
         r_addr[rn & 63] = lb_raddr;
         r_cyc[rn & 63]  = cyc;
         rn++;
      end
      if (lb_wen === 1'b1 && lb_ren === 1'b1) conflict_n++;
      if (job_valid === 1'b1 && job_ready === 1'b1) acc_n++;
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a job while idle; returns one cycle after acceptance.
   task automatic start_job(input logic [31:0] d, input logic [15:0] c);
      job_data  = d;
      job_ctrl  = c;
      job_valid = 1'b1;
      step();
      job_valid = 1'b0;
   endtask

   // lat counts cycles from acceptance (acceptance cycle = 0).
   task automatic wait_result(output int lat);
      lat = 1;
      while (res_valid !== 1'b1 && lat < 200) begin
         step();
         lat++;
      end
   endtask

   task automatic consume();
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed=no finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int wb, rb, lat, a0;
      rst = 1'b1; job_valid = 1'b0; job_data = '0; job_ctrl = '0; res_ready = 1'b0;
      repeat (3) step();

      check("rst_job_ready",   job_ready,   1);
      check("rst_res_valid",   res_valid,   0);
      check("rst_busy",        busy,        0);
      check("rst_wen",         lb_wen,      0);
      check("rst_ren",         lb_ren,      0);
      check("rst_res_status",  res_status,  0);
      check("rst_res_timeout", res_timeout, 0);
      check("rst_waddr",       lb_waddr,    0);
      check("rst_wdata",       lb_wdata,    0);
      check("rst_wstrb",       lb_wstrb,    0);
      check("rst_raddr",       lb_raddr,    0);
      rst = 1'b0;
      step();

      // Basic job, single poll.
      st_arr[rd_idx & 255] = 8'h01;
      wb = wn; rb = rn;
      start_job(32'hDEADBEEF, 16'h0100);
      check("basic_wen_after_accept", lb_wen, 1);
      wait_result(lat);
      check("basic_latency",  lat, 6);
      check("basic_nwrites",  wn - wb, 3);
      check("basic_w0_addr",  w_addr[wb & 63], 32'h0);
      check("basic_w0_data",  w_data[wb & 63], 32'hDEADBEEF);
      check("basic_w0_strb",  w_strb[wb & 63], 4'hF);
      check("basic_w1_addr",  w_addr[(wb+1) & 63], 32'h4);
      check("basic_w1_data",  w_data[(wb+1) & 63], 32'h00000100);
      check("basic_w1_strb",  w_strb[(wb+1) & 63], 4'h3);
      check("basic_w2_addr",  w_addr[(wb+2) & 63], 32'h100);
      check("basic_w2_data",  w_data[(wb+2) & 63], 32'h1);
      check("basic_w2_strb",  w_strb[(wb+2) & 63], 4'h1);
      check("basic_w_gap01",  w_cyc[(wb+1) & 63] - w_cyc[wb & 63], 1);
      check("basic_w_gap12",  w_cyc[(wb+2) & 63] - w_cyc[(wb+1) & 63], 1);
      check("basic_nreads",   rn - rb, 1);
      check("basic_raddr",    r_addr[rb & 63], 32'h8);
      check("basic_status",   res_status, 8'h01);
      check("basic_timeout",  res_timeout, 0);
      check("basic_busy",     busy, 1);
      check("basic_job_ready", job_ready, 0);
      consume();
      check("basic_res_valid_clr", res_valid, 0);
      check("basic_job_ready_set", job_ready, 1);
      check("basic_busy_clr",      busy, 0);

      // Write backpressure: 3 stall cycles per write.
      stall_en = 1'b1;
      st_arr[rd_idx & 255] = 8'h01;
      wb = wn; rb = rn;
      step();
      start_job(32'h12345678, 16'hA5A5);
      wait_result(lat);
      check("bp_latency",  lat, 15);
      check("bp_nwrites",  wn - wb, 3);
      check("bp_w0_data",  w_data[wb & 63], 32'h12345678);
      check("bp_w1_addr",  w_addr[(wb+1) & 63], 32'h4);
      check("bp_w1_data",  w_data[(wb+1) & 63], 32'h0000A5A5);
      check("bp_w2_addr",  w_addr[(wb+2) & 63], 32'h100);
      check("bp_w_gap01",  w_cyc[(wb+1) & 63] - w_cyc[wb & 63], 4);
      check("bp_w_gap12",  w_cyc[(wb+2) & 63] - w_cyc[(wb+1) & 63], 4);
      check("bp_hold_err", hold_err, 0);
      check("bp_rd_after_start", r_cyc[rb & 63] - w_cyc[(wb+2) & 63], 1);
      check("bp_status",   res_status, 8'h01);
      consume();
      stall_en = 1'b0;
      step();

      // Multi-poll: done on the final allowed poll wins over timeout.
      st_arr[rd_idx & 255]       = 8'h00;
      st_arr[(rd_idx + 1) & 255] = 8'h00;
      st_arr[(rd_idx + 2) & 255] = 8'h81;
      wb = wn; rb = rn;
      start_job(32'h0, 16'h0003);
      wait_result(lat);
      check("mp_latency", lat, 18);
      check("mp_nreads",  rn - rb, 3);
      check("mp_gap01",   r_cyc[(rb+1) & 63] - r_cyc[rb & 63], 6);
      check("mp_gap12",   r_cyc[(rb+2) & 63] - r_cyc[(rb+1) & 63], 6);
      check("mp_status",  res_status, 8'h81);
      check("mp_timeout", res_timeout, 0);
      consume();

      // Timeout: STATUS never done.
      for (int i = 0; i < 4; i++) st_arr[(rd_idx + i) & 255] = 8'h02;
      rb = rn;
      start_job(32'h00000077, 16'h0004);
      wait_result(lat);
      check("to_latency", lat, 18);
      check("to_nreads",  rn - rb, 3);
      check("to_status",  res_status, 8'h02);
      check("to_timeout", res_timeout, 1);
      consume();

      // Result backpressure with a second job waiting.
      st_arr[rd_idx & 255]       = 8'h01;
      st_arr[(rd_idx + 1) & 255] = 8'h01;
      start_job(32'h0BADF00D, 16'h0042);
      wait_result(lat);
      check("b2b_a_latency", lat, 6);
      job_data  = 32'hCAFEF00D;
      job_ctrl  = 16'h0077;
      job_valid = 1'b1;
      a0 = acc_n;
      for (int i = 0; i < 5; i++) begin
         step();
         check("b2b_hold_valid",  res_valid, 1);
         check("b2b_hold_status", res_status, 8'h01);
         check("b2b_job_ready",   job_ready, 0);
      end
      check("b2b_no_accept", acc_n - a0, 0);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check("b2b_res_valid_clr", res_valid, 0);
      check("b2b_ready_after",   job_ready, 1);
      step();
      job_valid = 1'b0;
      check("b2b_accepted",  acc_n - a0, 1);
      check("b2b_busy",      busy, 1);
      check("b2b_wen",       lb_wen, 1);
      check("b2b_waddr",     lb_waddr, 32'h0);
      check("b2b_wdata",     lb_wdata, 32'hCAFEF00D);
      wait_result(lat);
      check("b2b_b_latency", lat, 6);
      check("b2b_b_status",  res_status, 8'h01);
      consume();

      // Reset while waiting for read data; the late rvalid must be ignored.
      rd_delay = 3;
      st_arr[rd_idx & 255]       = 8'h01;
      st_arr[(rd_idx + 1) & 255] = 8'h01;
      start_job(32'h55AA55AA, 16'h0001);
      for (int i = 0; i < 20 && lb_ren !== 1'b1; i++) step();
      check("rmp_ren_seen", lb_ren, 1);
      step();
      check("rmp_in_wait", lb_ren, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rmp_job_ready",  job_ready, 1);
      check("rmp_res_valid",  res_valid, 0);
      check("rmp_busy",       busy, 0);
      check("rmp_wen",        lb_wen, 0);
      check("rmp_ren",        lb_ren, 0);
      check("rmp_res_status", res_status, 0);
      check("rmp_raddr",      lb_raddr, 0);
      wb = wn; rb = rn;
      repeat (6) step();
      check("rmp_late_res_valid", res_valid, 0);
      check("rmp_late_busy",      busy, 0);
      check("rmp_late_status",    res_status, 0);
      check("rmp_no_writes",      wn - wb, 0);
      check("rmp_no_reads",       rn - rb, 0);
      rd_delay = 0;
      start_job(32'h11112222, 16'h0202);
      wait_result(lat);
      check("rmp_fresh_latency", lat, 6);
      check("rmp_fresh_status",  res_status, 8'h01);
      check("rmp_fresh_timeout", res_timeout, 0);
      consume();

      check("wen_ren_overlap", conflict_n, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
